chu_gpo_ext: RTL and testbench

Parametrised general-purpose output slot core for the FPRO MMIO bus, successor to the plain GPO latch. It drives W output pins from a data register that can be written whole or manipulated per bit with set, clear and toggle. Selected bits can blink at a programmable rate, and a one-shot pulse can be fired on a bit mask for a programmable number of cycles. It occupies one slot and, unlike the basic GPO, supports readback of all registers.

---
 rtl/chu_gpo_ext.sv | 151 +++++++++++++++
 tb/tb_chu_gpo_ext.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chu_gpo_ext.sv
// MMIO general-purpose output slot: W output pins driven from a data register with
// per-bit set/clear/toggle, a per-bit blink engine and a retriggerable one-shot pulse.
module chu_gpo_ext #(
    parameter int W  = 8,
    parameter int CW = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [W-1:0] dout
);

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_SET      = 3'd1,
        REG_CLR      = 3'd2,
        REG_TGL      = 3'd3,
        REG_BLINK_EN = 3'd4,
        REG_PERIOD   = 3'd5,
        REG_PULSE    = 3'd6,
        REG_PLEN     = 3'd7
    } reg_e;

    logic [W-1:0]  data_q,     data_d;
    logic [W-1:0]  blink_en_q, blink_en_d;
    logic [CW-1:0] period_q,   period_d;
    logic [CW-1:0] bcnt_q,     bcnt_d;
    logic          phase_q,    phase_d;
    logic [W-1:0]  pmask_q,    pmask_d;
    logic [CW-1:0] pcnt_q,     pcnt_d;
    logic [CW-1:0] plen_q,     plen_d;

    reg_e          reg_sel;
    logic          addr_in_map;
    logic          wr_en;
    logic          pulse_active;
    logic [W-1:0]  wr_bits;
    logic [CW-1:0] wr_cnt;

    // read is accepted but never needed: reads are side-effect free and rd_data is combinational.
    logic unused_read;
    assign unused_read = read;

    assign reg_sel      = reg_e'(addr[2:0]);
    assign addr_in_map  = (addr[4:3] == 2'b00);
    assign wr_en        = cs && write && addr_in_map;
    assign pulse_active = (pcnt_q != '0);
    assign wr_bits      = wr_data[W-1:0];
    assign wr_cnt       = wr_data[CW-1:0];

    // Next-state logic: engines run first, then a bus write overrides what it touches.
    always_comb begin
        // NOTE: every *_d gets a default before any branch so no latch can be inferred.
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        bcnt_d     = bcnt_q;
        phase_d    = phase_q;
        pmask_d    = pmask_q;
        pcnt_d     = pcnt_q;
        plen_d     = plen_q;

        if (period_q == '0) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == period_q - CW'(1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d = bcnt_q + CW'(1);
        end

        if (pulse_active) begin
            pcnt_d = pcnt_q - CW'(1);
        end

        if (wr_en) begin
            unique case (reg_sel)
                REG_DATA:     data_d     = wr_bits;
                REG_SET:      data_d     = data_q | wr_bits;
                REG_CLR:      data_d     = data_q & ~wr_bits;
                REG_TGL:      data_d     = data_q ^ wr_bits;
                REG_BLINK_EN: blink_en_d = wr_bits;
                REG_PERIOD: begin
                    period_d = wr_cnt;
                    bcnt_d   = '0;
                    phase_d  = 1'b0;
                end
                REG_PULSE: begin
                    // A write on the edge the pulse would expire wins, so there is no gap.
                    pmask_d = wr_bits;
                    pcnt_d  = plen_q;
                end
                REG_PLEN:     plen_d     = wr_cnt;
                default:      ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            blink_en_q <= '0;
            period_q   <= '0;
            bcnt_q     <= '0;
            phase_q    <= 1'b0;
            pmask_q    <= '0;
            pcnt_q     <= '0;
            plen_q     <= '0;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
            pmask_q    <= pmask_d;
            pcnt_q     <= pcnt_d;
            plen_q     <= plen_d;
        end
    end

    // Pulse overrides blink; blinking bits are gated by the phase, others follow data.
    always_comb begin
        dout = ({W{pulse_active}} & pmask_q)
             | (data_q & (~blink_en_q | {W{phase_q}}));
    end

    always_comb begin
        rd_data = '0;
        if (addr_in_map) begin
            unique case (reg_sel)
                REG_DATA, REG_SET, REG_CLR, REG_TGL: rd_data = 32'(data_q);
                REG_BLINK_EN: rd_data = 32'(blink_en_q);
                REG_PERIOD:   rd_data = 32'(period_q);
                REG_PULSE: begin
                    rd_data     = 32'(pcnt_q);
                    rd_data[31] = pulse_active;
                end
                REG_PLEN:     rd_data = 32'(plen_q);
                default:      rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_chu_gpo_ext.sv
// Self-checking bench for chu_gpo_ext: directed steps from the test plan plus randomized
// bus traffic, compared every cycle against a time-based behavioural model.
module tb_chu_gpo_ext;

    localparam int W  = 8;
    localparam int CW = 24;

    logic          clk;
    logic          reset_n;
    logic          cs;
    logic          read;
    logic          write;
    logic [4:0]    addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic [W-1:0]  dout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: registers plus absolute cycle stamps for blink start and pulse end.
    int unsigned  cyc;
    logic [W-1:0] m_buf, m_ben, m_pmask;
    int unsigned  m_period, m_plen, m_bstart, m_pend;

    chu_gpo_ext #(.W(W), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int unsigned m_rem();
        return (cyc < m_pend) ? (m_pend - cyc) : 0;
    endfunction

    function automatic logic m_phase();
        if (m_period == 0) return 1'b0;
        return (((cyc - m_bstart) / m_period) % 2) == 1;
    endfunction

    function automatic logic [W-1:0] m_dout();
        logic [W-1:0] r;
        logic ph;
        ph = m_phase();
        for (int i = 0; i < W; i++) begin
            if (m_rem() != 0 && m_pmask[i]) r[i] = 1'b1;
            else if (m_ben[i])              r[i] = m_buf[i] & ph;
            else                            r[i] = m_buf[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd0, 5'd1, 5'd2, 5'd3: return 32'(m_buf);
            5'd4: return 32'(m_ben);
            5'd5: return m_period;
            5'd6: return m_rem() | ((m_rem() != 0) ? 32'h8000_0000 : 32'h0);
            5'd7: return m_plen;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        cyc = 0; m_buf = '0; m_ben = '0; m_pmask = '0;
        m_period = 0; m_plen = 0; m_bstart = 0; m_pend = 0;
    endtask

    task automatic model_edge(input logic we, input logic [4:0] a, input logic [31:0] d);
        cyc++;
        if (we && a < 5'd8) begin
            case (a)
                5'd0: m_buf = d[W-1:0];
                5'd1: m_buf = m_buf | d[W-1:0];
                5'd2: m_buf = m_buf & ~d[W-1:0];
                5'd3: m_buf = m_buf ^ d[W-1:0];
                5'd4: m_ben = d[W-1:0];
                5'd5: begin m_period = 32'(d[CW-1:0]); m_bstart = cyc; end
                5'd6: begin m_pmask = d[W-1:0]; m_pend = cyc + m_plen; end
                5'd7: m_plen = 32'(d[CW-1:0]);
                default: ;
            endcase
        end
    endtask

    // One bus cycle: drive, clock, then compare dout and rd_data on the falling edge.
    task automatic bus(input logic c, input logic w, input logic [4:0] a, input logic [31:0] d);
        cs = c; write = w; addr = a; wr_data = d;
        @(posedge clk);
        model_edge(c && w, a, d);
        @(negedge clk);
        check("dout", 32'(dout), 32'(m_dout()));
        check("rd_data", rd_data, m_read(a));
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus(1'b1, 1'b1, a, d);
    endtask

    task automatic idle(input logic [4:0] a);
        bus(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cs = 1'b0; write = 1'b0;
        #1;
        check("reset_dout", 32'(dout), 32'h0);
        for (int a = 0; a < 32; a++) begin
            addr = 5'(a);
            #1;
            check("reset_rd", rd_data, 32'h0);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [8:0] seq;
        int ones;
        logic [4:0] ra;
        logic [31:0] rd;
        logic rc, rw;

        reset_n = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0;
        model_reset();
        do_reset();

        // Write after reset is visible the following cycle.
        wr(5'd0, 32'hA5);
        check("data_a5_dout", 32'(dout), 32'hA5);
        check("data_a5_rd", rd_data, 32'h0000_00A5);

        // Bit operations act on the current data value.
        wr(5'd0, 32'hF0); check("bitop_data", rd_data, 32'hF0);
        wr(5'd1, 32'h03); check("bitop_set",  rd_data, 32'hF3);
        wr(5'd2, 32'h30); check("bitop_clr",  rd_data, 32'hC3);
        wr(5'd3, 32'h81); check("bitop_tgl",  rd_data, 32'h42);
        wr(5'd0, 32'h1FF); check("data_trunc", rd_data, 32'hFF);

        // Blink with period 3: bit 0 low 3, high 3, low 3; bits 3:1 steady.
        wr(5'd0, 32'h0F);
        wr(5'd4, 32'h01);
        wr(5'd5, 32'h3);
        seq = {8'h0, dout[0]};
        ones = (dout[3:1] == 3'b111) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            idle(5'd5);
            seq = {seq[7:0], dout[0]};
            ones += (dout[3:1] == 3'b111) ? 1 : 0;
        end
        check("blink_seq", 32'(seq), 32'(9'b000111000));
        check("blink_steady", ones, 9);

        wr(5'd5, 32'h0);
        for (int i = 0; i < 4; i++) idle(5'd0);
        check("blink_off", 32'(dout), 32'h0E);

        // Five-cycle pulse with status readback.
        wr(5'd0, 32'h0);
        wr(5'd4, 32'h0);
        wr(5'd7, 32'h5);
        wr(5'd6, 32'h80);
        check("pulse_dout", 32'(dout), 32'h80);
        check("pulse_stat5", rd_data, 32'h8000_0005);
        for (int i = 4; i >= 1; i--) begin
            idle(5'd6);
            check("pulse_dout", 32'(dout), 32'h80);
            check("pulse_stat", rd_data, 32'h8000_0000 | 32'(i));
        end
        idle(5'd6);
        check("pulse_end_dout", 32'(dout), 32'h0);
        check("pulse_end_stat", rd_data, 32'h0);

        // Retrigger on cycle 3 of a pulse moves it to the new mask for a full length.
        wr(5'd6, 32'h80);
        idle(5'd6);
        idle(5'd6);
        wr(5'd6, 32'h40);
        ones = 0;
        for (int i = 0; i < 5; i++) begin
            ones += (dout == 8'h40) ? 1 : 0;
            idle(5'd6);
        end
        check("retrig_len", ones, 5);
        check("retrig_end", 32'(dout), 32'h0);

        // Retrigger on the edge the count would reach zero: no gap.
        wr(5'd6, 32'h20);
        for (int i = 0; i < 4; i++) idle(5'd6);
        check("retrig_last", rd_data, 32'h8000_0001);
        wr(5'd6, 32'h10);
        check("retrig_nogap_dout", 32'(dout), 32'h10);
        check("retrig_nogap_stat", rd_data, 32'h8000_0005);
        for (int i = 0; i < 5; i++) idle(5'd6);

        // Zero pulse length produces no pulse.
        wr(5'd7, 32'h0);
        wr(5'd0, 32'h3C);
        wr(5'd6, 32'hFF);
        check("plen0_dout", 32'(dout), 32'h3C);
        check("plen0_stat", rd_data, 32'h0);
        idle(5'd6);

        // Pulse held high across both blink phases.
        wr(5'd0, 32'h01);
        wr(5'd4, 32'h01);
        wr(5'd5, 32'h2);
        wr(5'd7, 32'h8);
        wr(5'd6, 32'h01);
        ones = dout[0] ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            idle(5'd6);
            ones += dout[0] ? 1 : 0;
        end
        check("pulse_over_blink", ones, 8);

        // Out-of-map address: no register changes, reads zero.
        wr(5'd9, 32'hFFFF_FFFF);
        check("addr9_rd", rd_data, 32'h0);
        for (int a = 0; a < 8; a++) idle(5'(a));

        // Asynchronous reset in the middle of a pulse with blinking active.
        wr(5'd0, 32'hFF);
        wr(5'd4, 32'hF0);
        wr(5'd7, 32'h6);
        wr(5'd6, 32'h0F);
        idle(5'd0);
        #2;
        do_reset();
        for (int i = 0; i < 3; i++) idle(5'd6);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            ra = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) ra = 5'($urandom_range(16, 31));
            rc = ($urandom_range(0, 3) != 0);
            rw = 1'($urandom_range(0, 1));
            rd = $urandom;
            if (ra == 5'd5 || ra == 5'd7)
                rd = (rd & 32'hFF00_0000) | 32'($urandom_range(0, 6));
            read = 1'($urandom_range(0, 1));
            bus(rc, rw, ra, rd);
            if (i == 200) begin
                #2;
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
